word_serializer: RTL and testbench

//   Parallel-to-serial feeder for the serial pattern detector. Accepts DATA_W-bit

---
 rtl/word_serializer.sv | 141 ++++++++++++++
 tb/tb_word_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial feeder for the serial pattern detector.
// Accepts DATA_W-bit words over valid/ready and emits one bit per cycle on
// ser_out/ser_en, with a registered one-cycle word_done pulse per word.
// Optional feature macro: WORD_SERIALIZER_PREFETCH_EN (one-word prefetch
// register for a bubble-free stream across back-to-back words).
module word_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ser_hold,
    output logic              ser_out,
    output logic              ser_en,
    output logic              busy,
    output logic              word_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [DATA_W-1:0] shreg_shifted;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic              word_done_nxt;
    logic              accept;
    logic              last_bit;

`ifdef WORD_SERIALIZER_PREFETCH_EN
    logic [DATA_W-1:0] pf_data;
    logic [DATA_W-1:0] pf_data_nxt;
    logic              pf_valid;
    logic              pf_valid_nxt;

    assign in_ready = ~pf_valid;
`else
    assign in_ready = (state == IDLE);
`endif

    assign busy     = (state == SHIFT);
    assign ser_en   = busy & ~ser_hold;
    assign ser_out  = busy & (MSB_FIRST ? shreg[DATA_W-1] : shreg[0]);
    assign accept   = in_valid & in_ready;
    assign last_bit = ser_en & (bit_cnt == CNT_W'(1));

    // Shift toward the output end with zero fill.
    always_comb begin
        if (MSB_FIRST) begin
            shreg_shifted = {shreg[DATA_W-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg[DATA_W-1:1]};
        end
    end

    // State, shift register, counter and done pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
`ifdef WORD_SERIALIZER_PREFETCH_EN
            pf_data   <= '0;
            pf_valid  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            word_done <= word_done_nxt;
`ifdef WORD_SERIALIZER_PREFETCH_EN
            pf_data   <= pf_data_nxt;
            pf_valid  <= pf_valid_nxt;
`endif
        end
    end

    // Next-state and datapath update: load on accept, shift on ser_en, finish on last bit.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        word_done_nxt = 1'b0;
`ifdef WORD_SERIALIZER_PREFETCH_EN
        pf_data_nxt   = pf_data;
        pf_valid_nxt  = pf_valid;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt   = in_data;
                    bit_cnt_nxt = CNT_W'(DATA_W);
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    shreg_nxt   = shreg_shifted;
                    bit_cnt_nxt = bit_cnt - CNT_W'(1);
                end
                if (last_bit) begin
                    word_done_nxt = 1'b1;
                    state_nxt     = IDLE;
`ifdef WORD_SERIALIZER_PREFETCH_EN
                    // Chain straight into the next word so the stream has no bubble.
                    if (pf_valid) begin
                        shreg_nxt    = pf_data;
                        bit_cnt_nxt  = CNT_W'(DATA_W);
                        pf_valid_nxt = 1'b0;
                        state_nxt    = SHIFT;
                    end else if (accept) begin
                        shreg_nxt   = in_data;
                        bit_cnt_nxt = CNT_W'(DATA_W);
                        state_nxt   = SHIFT;
                    end
`endif
                end
`ifdef WORD_SERIALIZER_PREFETCH_EN
                else if (accept) begin
                    pf_data_nxt  = in_data;
                    pf_valid_nxt = 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: two instances (MSB-first and
// LSB-first) share the stimulus; expected bits are queued on send and
// popped by per-instance monitors whenever ser_en is sampled high.
module tb_word_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } item_t;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_hold;
    logic       ready_m, out_m, en_m, busy_m, done_m;
    logic       ready_l, out_l, en_l, busy_l, done_l;

    item_t q_m[$];
    item_t q_l[$];
    logic  pend_m, pend_l;
    int    checks, errors;
    int    run_len, gap_len, last_run, last_gap;

    word_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_m), .ser_hold(ser_hold), .ser_out(out_m),
        .ser_en(en_m), .busy(busy_m), .word_done(done_m)
    );

    word_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_l), .ser_hold(ser_hold), .ser_out(out_l),
        .ser_en(en_l), .busy(busy_l), .word_done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the expected bit streams of one word for both bit orders.
    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            q_m.push_back('{b: w[7-i], last: (i == 7)});
            q_l.push_back('{b: w[i],   last: (i == 7)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold in_valid until it is accepted.
    task automatic send(input logic [7:0] w);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!ready_m && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'(0));
        push_word(w);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_m || q_m.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(n), 32'(0));
        repeat (2) tick();
    endtask

    // MSB-first monitor: pop on ser_en, frozen-output check during hold, done pulse check.
    always @(negedge clk) begin
        if (!rst) begin
            pend_m = 1'b0;
        end else begin
            check("done_msb", 32'(done_m), 32'(pend_m));
            pend_m = 1'b0;
            if (en_m) begin
                if (q_m.size() == 0) begin
                    check("extra_bit_msb", 32'(1), 32'(0));
                end else begin
                    item_t it;
                    it = q_m.pop_front();
                    check("bit_msb", 32'(out_m), 32'(it.b));
                    pend_m = it.last;
                end
            end else if (busy_m && q_m.size() != 0) begin
                check("hold_msb", 32'(out_m), 32'(q_m[0].b));
            end
        end
    end

    // LSB-first monitor.
    always @(negedge clk) begin
        if (!rst) begin
            pend_l = 1'b0;
        end else begin
            check("done_lsb", 32'(done_l), 32'(pend_l));
            pend_l = 1'b0;
            if (en_l) begin
                if (q_l.size() == 0) begin
                    check("extra_bit_lsb", 32'(1), 32'(0));
                end else begin
                    item_t it;
                    it = q_l.pop_front();
                    check("bit_lsb", 32'(out_l), 32'(it.b));
                    pend_l = it.last;
                end
            end else if (busy_l && q_l.size() != 0) begin
                check("hold_lsb", 32'(out_l), 32'(q_l[0].b));
            end
        end
    end

    // Run/gap length tracker on the MSB-first instance's ser_en.
    always @(negedge clk) begin
        if (!rst) begin
            run_len = 0;
            gap_len = 0;
        end else if (en_m) begin
            if (run_len == 0) last_gap = gap_len;
            run_len++;
            gap_len = 0;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            gap_len++;
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        last_run = 0;
        last_gap = 0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        ser_hold = 1'b0;
        rst      = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_ser_out", 32'(out_m), 32'(0));
        check("rst_ser_en", 32'(en_m), 32'(0));
        check("rst_busy", 32'(busy_m), 32'(0));
        check("rst_in_ready", 32'(ready_m), 32'(1));
        check("rst_word_done", 32'(done_m), 32'(0));
        rst = 1'b1;
        tick();

        // Single word, both bit orders.
        send(8'hB5);
        wait_idle();

        // Back-to-back words with in_valid held high.
        send(8'hFF);
        send(8'h00);
        wait_idle();
`ifdef WORD_SERIALIZER_PREFETCH_EN
        check("b2b_run", 32'(last_run), 32'(16));
`else
        check("b2b_run", 32'(last_run), 32'(8));
        check("b2b_gap", 32'(last_gap), 32'(1));
`endif

        // Three-cycle hold after the second bit.
        send(8'hB5);
        tick();
        tick();
        ser_hold = 1'b1;
        #1;
        check("hold_en_drop", 32'(en_m), 32'(0));
        repeat (3) tick();
        ser_hold = 1'b0;
        wait_idle();

        // Reset mid-word after four bits, then a clean word.
        send(8'hB5);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("midrst_ser_en", 32'(en_m), 32'(0));
        check("midrst_busy", 32'(busy_m), 32'(0));
        check("midrst_done", 32'(done_m), 32'(0));
        q_m.delete();
        q_l.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        send(8'h35);
        wait_idle();

`ifndef WORD_SERIALIZER_PREFETCH_EN
        // in_valid while busy is ignored and in_data changes do not leak.
        send(8'h3C);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        #1;
        check("busy_in_ready", 32'(ready_m), 32'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            in_data = ~in_data;
            check("busy_in_ready_loop", 32'(ready_m), 32'(0));
        end
        in_valid = 1'b0;
        wait_idle();
        check("busy_not_accepted", 32'(busy_m), 32'(0));
`endif

        check("queue_empty_msb", 32'(q_m.size()), 32'(0));
        check("queue_empty_lsb", 32'(q_l.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
